// File: rtl/tank_controller.sv
// tank_controller: once per frame, moves the player tank and sets its facing and tread animation.
// Optional build macro TANK_TURN_SNAP_EN: on a turn, snap the cross axis to the 8-pixel field grid.
module tank_controller #(
  parameter int unsigned FIELD_X0    = 60,
  parameter int unsigned FIELD_Y0    = 30,
  parameter int unsigned FIELD_W     = 512,
  parameter int unsigned FIELD_H     = 448,
  parameter int unsigned TANK_SIZE   = 32,
  parameter int unsigned STEP        = 1,
  parameter int unsigned START_X     = 220,
  parameter int unsigned START_Y     = 446,
  parameter int unsigned ANIM_FRAMES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] TankX,
  output logic [9:0] TankY,
  output logic [9:0] TankS_X,
  output logic [9:0] TankS_Y,
  output logic [2:0] Direction,
  output logic       Moving,
  output logic [1:0] Anim_Frame
);

  localparam int unsigned CW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic signed [10:0] X_MIN  = 11'(FIELD_X0);
  localparam logic signed [10:0] X_MAX  = 11'(FIELD_X0 + FIELD_W - TANK_SIZE);
  localparam logic signed [10:0] Y_MIN  = 11'(FIELD_Y0);
  localparam logic signed [10:0] Y_MAX  = 11'(FIELD_Y0 + FIELD_H - TANK_SIZE);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic [CW-1:0]      CNT_LAST = CW'(ANIM_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, TURN, MOVE, BLOCKED} state_t;

  function automatic logic signed [10:0] clamp(input logic signed [10:0] v,
                                               input logic signed [10:0] lo,
                                               input logic signed [10:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

`ifdef TANK_TURN_SNAP_EN
  // Round to the nearest 8-pixel grid line measured from the field origin.
  function automatic logic signed [10:0] snap(input logic signed [10:0] v,
                                              input logic signed [10:0] org,
                                              input logic signed [10:0] hi);
    logic signed [10:0] off;
    off = v - org;
    return clamp(org + (((off + 11'sd4) >>> 3) <<< 3), org, hi);
  endfunction
`endif

  state_t             state;
  logic               sync1, sync2, prev, tick;
  logic [CW-1:0]      anim_cnt;
  logic               req_valid;
  logic [1:0]         req_dir;
  logic signed [10:0] x_cur, y_cur, x_mv, y_mv, x_turn, y_turn;
  logic               blocked;

  assign tick    = sync2 & ~prev;
  assign TankS_X = 10'(TANK_SIZE);
  assign TankS_Y = 10'(TANK_SIZE);
  assign Moving  = (state == MOVE);

  // Key decode plus candidate positions for a move and for a turn.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = 2'd0;
    case (keycode)
      8'h1A:   req_dir = 2'd0;
      8'h07:   req_dir = 2'd1;
      8'h16:   req_dir = 2'd2;
      8'h04:   req_dir = 2'd3;
      default: req_valid = 1'b0;
    endcase

    x_cur = $signed({1'b0, TankX});
    y_cur = $signed({1'b0, TankY});
    x_mv  = x_cur;
    y_mv  = y_cur;
    case (Direction)
      3'd0:    y_mv = clamp(y_cur - STEP_S, Y_MIN, Y_MAX);
      3'd1:    x_mv = clamp(x_cur + STEP_S, X_MIN, X_MAX);
      3'd2:    y_mv = clamp(y_cur + STEP_S, Y_MIN, Y_MAX);
      3'd3:    x_mv = clamp(x_cur - STEP_S, X_MIN, X_MAX);
      default: ;
    endcase
    blocked = (x_mv == x_cur) && (y_mv == y_cur);

    x_turn = x_cur;
    y_turn = y_cur;
`ifdef TANK_TURN_SNAP_EN
    if (req_dir[0]) y_turn = snap(y_cur, Y_MIN, Y_MAX);
    else            x_turn = snap(x_cur, X_MIN, X_MAX);
`endif
  end

  // Frame-edge synchroniser, motion FSM and tread animation.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      prev       <= 1'b1;
      TankX      <= 10'(START_X);
      TankY      <= 10'(START_Y);
      Direction  <= 3'd0;
      state      <= IDLE;
      anim_cnt   <= '0;
      Anim_Frame <= 2'd0;
    end else begin
      sync1 <= frame_clk;
      sync2 <= sync1;
      prev  <= sync2;
      if (tick) begin
        if (!req_valid) begin
          state <= IDLE;
        end else if ({1'b0, req_dir} != Direction) begin
          state     <= TURN;
          Direction <= {1'b0, req_dir};
          TankX     <= 10'(x_turn);
          TankY     <= 10'(y_turn);
        end else if (blocked) begin
          state <= BLOCKED;
        end else begin
          state <= MOVE;
          TankX <= 10'(x_mv);
          TankY <= 10'(y_mv);
          if (anim_cnt == CNT_LAST) begin
            anim_cnt   <= '0;
            Anim_Frame <= Anim_Frame + 2'd1;
          end else begin
            anim_cnt <= anim_cnt + CW'(1);
          end
        end
      end
    end
  end

endmodule
